// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between the CPU and a DMA/debug master.
// Optional build macro MEM_TIMEOUT_EN adds an access timeout that aborts and pulses mem_err.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          res,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          mem_err
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t        state;
    logic [SW-1:0] starveCnt;
    logic          cpuReq;
    logic          dmaWins;
    logic          timeoutHit;
    logic          accDone;

    assign cpuReq  = cpu_rd | cpu_wr;
    // A starved DMA beats the CPU; otherwise DMA only wins an idle port.
    assign dmaWins = dma_req && ((starveCnt == SW'(STARVE_MAX)) || !cpuReq);
    assign accDone = mem_ready || timeoutHit;

    assign cpu_stall = cpuReq && !(state == CPU_ACC && accDone);

`ifdef MEM_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] waitCnt;

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            waitCnt <= '0;
        else if (state == IDLE)
            waitCnt <= '0;
        else if (!mem_ready)
            waitCnt <= waitCnt + WW'(1);
    end

    // Fires on the TIMEOUT-th access cycle that still has no mem_ready.
    assign timeoutHit = (state != IDLE) && !mem_ready && (waitCnt == WW'(TIMEOUT - 1));
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT != 0);
    assign timeoutHit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            dma_done  <= 1'b0;
            mem_err   <= 1'b0;
            starveCnt <= '0;
        end else begin
            dma_done <= 1'b0;
            mem_err  <= timeoutHit;

            if (!dma_req)
                starveCnt <= '0;
            else if (starveCnt != SW'(STARVE_MAX))
                starveCnt <= starveCnt + SW'(1);

            case (state)
                IDLE: begin
                    if (dmaWins) begin
                        state     <= DMA_ACC;
                        mem_en    <= 1'b1;
                        mem_we    <= dma_we;
                        mem_addr  <= dma_addr;
                        mem_wdata <= dma_wdata;
                        starveCnt <= '0;
                    end else if (cpuReq) begin
                        state     <= CPU_ACC;
                        mem_en    <= 1'b1;
                        mem_we    <= cpu_wr;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                    end
                end
                CPU_ACC: begin
                    if (accDone) begin
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (mem_ready && !mem_we)
                            cpu_rdata <= mem_rdata;
                    end
                end
                DMA_ACC: begin
                    if (accDone) begin
                        state    <= IDLE;
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        dma_done <= 1'b1;
                        if (mem_ready && !mem_we)
                            dma_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; covers the MEM_TIMEOUT_EN build when defined.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic [DW-1:0] dma_rdata;
    logic          dma_done;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          mem_err;

    int nChk = 0;
    int nBad = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8), .TIMEOUT(15)) dut (
        .clk(clk), .res(res),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts CPU grants until the DMA address shows up on the port (bounded).
    task automatic countUntilDma(output int n);
        bit found = 0;
        n = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (mem_en) begin
                if (mem_addr == 32'h300) found = 1;
                else n++;
            end
        end
        if (!found) n = 99;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int stallCnt;
        int errCnt;

        // reset
        #2 res = 1'b0;
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_dma_done", dma_done, 0);
        chk("rst_mem_err", mem_err, 0);
        tick(); tick();
        res = 1'b1;
        tick();

        // CPU read, zero-wait
        cpu_rd = 1; cpu_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h1234ABCD;
        #1;
        chk("rd0_stall", cpu_stall, 1);
        chk("rd0_en", mem_en, 0);
        tick();
        chk("rd1_en", mem_en, 1);
        chk("rd1_addr", mem_addr, 32'h40);
        chk("rd1_we", mem_we, 0);
        chk("rd1_stall", cpu_stall, 0);
        cpu_rd = 0;
        tick();
        chk("rd2_en", mem_en, 0);
        chk("rd2_rdata", cpu_rdata, 32'h1234ABCD);

        // CPU write, 3 wait states
        mem_ready = 0; cpu_wr = 1; cpu_addr = 32'h80; cpu_wdata = 32'hCAFEF00D;
        mem_rdata = 32'hFFFFFFFF;
        #1;
        chk("wr0_stall", cpu_stall, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("wrw_en", mem_en, 1);
            chk("wrw_we", mem_we, 1);
            chk("wrw_addr", mem_addr, 32'h80);
            chk("wrw_wdata", mem_wdata, 32'hCAFEF00D);
            chk("wrw_stall", cpu_stall, 1);
        end
        tick();
        mem_ready = 1;
        #1;
        chk("wr4_stall", cpu_stall, 0);
        chk("wr4_we", mem_we, 1);
        chk("wr4_wdata", mem_wdata, 32'hCAFEF00D);
        cpu_wr = 0;
        tick();
        chk("wr5_en", mem_en, 0);
        chk("wr5_we", mem_we, 0);
        chk("wr5_rdata_kept", cpu_rdata, 32'h1234ABCD);

        // simultaneous CPU read and DMA read: CPU first
        cpu_rd = 1; cpu_addr = 32'h44; mem_rdata = 32'h44445555;
        dma_req = 1; dma_we = 0; dma_addr = 32'h100;
        tick();
        chk("sim1_addr", mem_addr, 32'h44);
        chk("sim1_en", mem_en, 1);
        chk("sim1_done", dma_done, 0);
        cpu_rd = 0;
        tick();
        chk("sim2_en", mem_en, 0);
        chk("sim2_cpu_rdata", cpu_rdata, 32'h44445555);
        mem_rdata = 32'hD0D0D0D0;
        tick();
        chk("sim3_en", mem_en, 1);
        chk("sim3_addr", mem_addr, 32'h100);
        chk("sim3_we", mem_we, 0);
        tick();
        chk("sim4_done", dma_done, 1);
        chk("sim4_dma_rdata", dma_rdata, 32'hD0D0D0D0);
        chk("sim4_en", mem_en, 0);
        dma_req = 0;
        tick();
        chk("sim5_done", dma_done, 0);

        // starvation: CPU hammers the port while DMA waits
        cpu_rd = 1; cpu_addr = 32'h200;
        dma_req = 1; dma_we = 1; dma_addr = 32'h300; dma_wdata = 32'hBEEF;
        countUntilDma(n);
        chk("starve1_cpu_grants", n, 4);
        chk("starve1_we", mem_we, 1);
        chk("starve1_wdata", mem_wdata, 32'hBEEF);
        tick();
        chk("starve1_done", dma_done, 1);
        countUntilDma(n);
        chk("starve2_cpu_grants", n, 4);
        tick();
        chk("starve2_done", dma_done, 1);
        cpu_rd = 0; dma_req = 0;
        tick();

        // reset in the middle of a DMA access
        mem_ready = 0; dma_req = 1; dma_we = 1; dma_addr = 32'h500; dma_wdata = 32'h77;
        tick();
        chk("rdma1_en", mem_en, 1);
        tick();
        chk("rdma2_en", mem_en, 1);
        #2 res = 1'b0;
        #1;
        chk("rdma_en_drop", mem_en, 0);
        chk("rdma_we_drop", mem_we, 0);
        chk("rdma_addr_clr", mem_addr, 0);
        dma_req = 0;
        tick(); tick();
        res = 1'b1;
        chk("rdma_done_a", dma_done, 0);
        tick();
        chk("rdma_done_b", dma_done, 0);
        chk("rdma_cpu_rdata_clr", cpu_rdata, 0);
        mem_ready = 1; cpu_rd = 1; cpu_addr = 32'h48; mem_rdata = 32'h5555AAAA;
        tick();
        chk("post_en", mem_en, 1);
        chk("post_addr", mem_addr, 32'h48);
        chk("post_done", dma_done, 0);
        cpu_rd = 0;
        tick();
        chk("post_rdata", cpu_rdata, 32'h5555AAAA);

        // long wait with no mem_ready
        mem_ready = 0; cpu_rd = 1; cpu_addr = 32'h60; mem_rdata = 32'h600D;
        stallCnt = 0; errCnt = 0;
`ifdef MEM_TIMEOUT_EN
        #1;
        chk("to0_stall", cpu_stall, 1);
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (cpu_stall && mem_en) stallCnt++;
            if (mem_err) errCnt++;
        end
        chk("to_stall_cycles", stallCnt, 14);
        tick();
        chk("to15_stall", cpu_stall, 0);
        chk("to15_en", mem_en, 1);
        chk("to15_err", mem_err, 0);
        cpu_rd = 0;
        tick();
        chk("to16_en", mem_en, 0);
        chk("to16_err", mem_err, 1);
        chk("to16_rdata", cpu_rdata, 32'h5555AAAA);
        tick();
        chk("to17_err", mem_err, 0);
        chk("to_err_early", errCnt, 0);
`else
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_stall && mem_en) stallCnt++;
            if (mem_err) errCnt++;
        end
        chk("wait_stall_cycles", stallCnt, 20);
        chk("wait_err_cycles", errCnt, 0);
        mem_ready = 1;
        #1;
        chk("wait_stall_end", cpu_stall, 0);
        cpu_rd = 0;
        tick();
        chk("wait_rdata", cpu_rdata, 32'h600D);
        chk("wait_en", mem_en, 0);
        chk("wait_err", mem_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", nChk, nBad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the multicycle CPU control/datapath and a DMA/debug requester.
- Sequences each memory access, including variable-latency memories with mem_ready handshake.
- Back-pressures the CPU control FSM through cpu_stall.
- Fixed CPU priority, with a starvation counter that forces a DMA grant.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_MAX, 8, consecutive cycles a pending DMA request may be denied before it wins the next arbitration
TIMEOUT, 15, cycles without mem_ready before abort (only used with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
res  in  1  reset, asynchronous, active-low
cpu_rd  in  1  CPU memory read request (from MemRead)
cpu_wr  in  1  CPU memory write request (from MemWrite)
cpu_addr  in  AW  CPU address (PC or ALUOut per IorD)
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  registered CPU read data
cpu_stall  out  1  CPU must hold its current state
dma_req  in  1  DMA request, level, held until dma_done
dma_we  in  1  DMA write (1) / read (0)
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_rdata  out  DW  registered DMA read data
dma_done  out  1  one-cycle completion pulse
mem_en  out  1  memory access active
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current access this cycle
mem_err  out  1  one-cycle timeout pulse (constant 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (res low, async): state=IDLE; mem_en, mem_we, dma_done, mem_err=0; mem_addr, mem_wdata, cpu_rdata, dma_rdata=0; starve_cnt=0. Reset mid-access drops mem_en immediately and loses the access.
- States: IDLE, CPU_ACC, DMA_ACC.
- cpu_req = cpu_rd | cpu_wr. If both are high, the access is a write.
- IDLE arbitration, evaluated each rising edge:
  - if dma_req && starve_cnt==STARVE_MAX -> DMA_ACC
  - else if cpu_req -> CPU_ACC
  - else if dma_req -> DMA_ACC
  - else stay in IDLE.
- On a grant edge, register the winner's address, wdata and write flag into mem_addr, mem_wdata, mem_we, and set mem_en=1. All of these are held constant for the whole access.
- In CPU_ACC or DMA_ACC with mem_ready=1:
  - next state IDLE; mem_en, mem_we -> 0.
  - For a read, mem_rdata is registered into cpu_rdata or dma_rdata. The value holds until the next read completion for that port.
- dma_done=1 for exactly the one cycle after a DMA access completes.
- cpu_stall (combinational) = cpu_req && !(state==CPU_ACC && mem_ready).
  - Zero-wait memory: request in cycle 0, stall=1 in cycle 0, access in cycle 1, stall=0 in cycle 1, cpu_rdata valid from cycle 2.
- Every access returns to IDLE for one cycle, so back-to-back accesses cost a minimum of 2 cycles each.
- starve_cnt:
  - cleared when dma_req=0 or on a DMA grant;
  - otherwise incremented each cycle dma_req=1, saturating at STARVE_MAX.
- A requester dropping its request mid-access does not abort the access. It completes normally, and dma_done still pulses for DMA.
- A CPU request arriving during DMA_ACC: cpu_stall=1 until its own CPU_ACC completes.
- No combinational path from mem_ready to mem_en or mem_addr.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - a wait counter clears on entry to any access state and increments each access cycle with mem_ready=0.
  - When it reaches TIMEOUT: abort to IDLE, mem_en=0, mem_err pulses one cycle, read data registers unchanged.
  - CPU abort: cpu_stall drops in the abort cycle.
  - DMA abort: dma_done pulses the cycle after.
- MEM_TIMEOUT_EN undefined: no counter; accesses wait indefinitely; mem_err constant 0.

Test Plan:
- CPU read, zero-wait: cpu_rd=1, cpu_addr=0x40, mem_ready tied 1, mem_rdata=0x1234ABCD -> stall high 1 cycle, mem_en high 1 cycle, cpu_rdata=0x1234ABCD next cycle.
- CPU write with 3 wait states: cpu_wr=1, addr 0x80, data 0xCAFEF00D, mem_ready on the 4th access cycle -> mem_we/mem_addr/mem_wdata stable 4 cycles, stall high 4 cycles total.
- Simultaneous cpu_rd and dma_req in IDLE with starve_cnt=0 -> CPU granted first; DMA granted at the next IDLE; dma_done pulses once.
- Starvation: dma_req held while CPU requests continuously (zero-wait) -> after starve_cnt reaches 8, DMA wins the next IDLE arbitration despite cpu_req=1; starve_cnt returns to 0.
- Reset asserted mid-DMA access (mem_ready=0) -> mem_en 0 immediately, state IDLE, dma_done never pulses; after release, a new CPU read works.
- With MEM_TIMEOUT_EN: CPU read, mem_ready held 0 -> abort after 15 access cycles, mem_err pulses once, cpu_stall drops, cpu_rdata unchanged.
